// File: rtl/output_mems.sv
// output_mems: result RAM plus AXI-Stream transmitter for the conv accelerator.
// Optional TLAST output is enabled by defining OUTPUT_MEMS_TLAST_EN.
`timescale 1ns/1ps
module output_mems #(
    parameter  int OUTW        = 32,
    parameter  int R           = 15,
    parameter  int C           = 13,
    parameter  int MAXK        = 7,
    localparam int K_BITS      = $clog2(MAXK + 1),
    localparam int Y_ADDR_BITS = $clog2(R * C)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [K_BITS-1:0]      K,
    input  logic                   y_wr_en,
    input  logic [Y_ADDR_BITS-1:0] y_wr_addr,
    input  logic [OUTW-1:0]        y_wr_data,
    input  logic                   compute_finished,
    output logic                   output_busy,
    output logic                   outputs_sent,
    output logic [OUTW-1:0]        AXIS_TDATA,
    output logic                   AXIS_TVALID,
    input  logic                   AXIS_TREADY
`ifdef OUTPUT_MEMS_TLAST_EN
    ,
    output logic                   AXIS_TLAST
`endif
);

    localparam int DEPTH = R * C;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [OUTW-1:0] mem [DEPTH];
    logic [OUTW-1:0] rd_data_q;

    logic [Y_ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [Y_ADDR_BITS-1:0] n_q, n_d;
    logic [Y_ADDR_BITS-1:0] n_calc;
    int                     rows, cols;

    // stage A: RAM read register; stage B: AXIS output register
    logic            av_q, av_d;
    logic            al_q, al_d;
    logic            bv_q, bv_d;
    logic            bl_q, bl_d;
    logic [OUTW-1:0] bd_q, bd_d;

    logic wr_en, rd_en, b_ready, xfer_last;

    assign b_ready   = !bv_q || AXIS_TREADY;
    assign xfer_last = bv_q && AXIS_TREADY && bl_q;
    assign wr_en     = (state_q == S_IDLE) && y_wr_en
                       && (int'(y_wr_addr) < DEPTH);
    assign rd_en     = ((state_q == S_FETCH) || (state_q == S_STREAM))
                       && (ptr_q < n_q) && (!av_q || b_ready);

    // Beat count of a frame; zero for an unusable filter size
    always_comb begin
        rows   = R - int'(K) + 1;
        cols   = C - int'(K) + 1;
        n_calc = '0;
        if (K != '0 && rows > 0 && cols > 0) begin
            n_calc = Y_ADDR_BITS'(rows * cols);
        end
    end

    // Result RAM: synchronous write, registered read
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[y_wr_addr] <= y_wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[ptr_q];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (compute_finished) begin
                    state_d = (n_calc == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH:  state_d = S_STREAM;
            S_STREAM: if (xfer_last) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        output_busy  = (state_q != S_IDLE);
        outputs_sent = (state_q == S_DONE);
    end

    // Read pointer and two-entry prefetch pipeline next state
    always_comb begin
        ptr_d = ptr_q;
        n_d   = n_q;
        av_d  = av_q;
        al_d  = al_q;
        bv_d  = bv_q;
        bl_d  = bl_q;
        bd_d  = bd_q;
        if (state_q == S_IDLE) begin
            av_d = 1'b0;
            bv_d = 1'b0;
            bl_d = 1'b0;
            if (compute_finished) begin
                n_d   = n_calc;
                ptr_d = '0;
            end
        end else begin
            if (b_ready) begin
                bv_d = av_q;
                bl_d = av_q && al_q;
                if (av_q) begin
                    bd_d = rd_data_q;
                end
            end
            if (rd_en) begin
                av_d  = 1'b1;
                al_d  = (ptr_q == n_q - 1'b1);
                ptr_d = ptr_q + 1'b1;
            end else if (b_ready) begin
                av_d = 1'b0;
            end
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
            n_q   <= '0;
            av_q  <= 1'b0;
            al_q  <= 1'b0;
            bv_q  <= 1'b0;
            bl_q  <= 1'b0;
            bd_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            n_q   <= n_d;
            av_q  <= av_d;
            al_q  <= al_d;
            bv_q  <= bv_d;
            bl_q  <= bl_d;
            bd_q  <= bd_d;
        end
    end

    assign AXIS_TVALID = bv_q;
    assign AXIS_TDATA  = bd_q;
`ifdef OUTPUT_MEMS_TLAST_EN
    assign AXIS_TLAST  = bl_q;
`endif

endmodule

// File: tb/tb_output_mems.sv
// tb_output_mems: randomized scoreboard bench for output_mems.
// Expected beats come from a simple array model of the result RAM.
`timescale 1ns/1ps
module tb_output_mems;

    localparam int OUTW  = 32;
    localparam int R     = 15;
    localparam int C     = 13;
    localparam int MAXK  = 15;
    localparam int KB    = 4;
    localparam int AB    = 8;
    localparam int DEPTH = R * C;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [KB-1:0]   K = '0;
    logic            y_wr_en = 1'b0;
    logic [AB-1:0]   y_wr_addr = '0;
    logic [OUTW-1:0] y_wr_data = '0;
    logic            compute_finished = 1'b0;
    logic            output_busy;
    logic            outputs_sent;
    logic [OUTW-1:0] AXIS_TDATA;
    logic            AXIS_TVALID;
    logic            AXIS_TREADY = 1'b0;
`ifdef OUTPUT_MEMS_TLAST_EN
    logic            AXIS_TLAST;
`endif

    output_mems #(
        .OUTW(OUTW),
        .R(R),
        .C(C),
        .MAXK(MAXK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .K(K),
        .y_wr_en(y_wr_en),
        .y_wr_addr(y_wr_addr),
        .y_wr_data(y_wr_data),
        .compute_finished(compute_finished),
        .output_busy(output_busy),
        .outputs_sent(outputs_sent),
        .AXIS_TDATA(AXIS_TDATA),
        .AXIS_TVALID(AXIS_TVALID),
        .AXIS_TREADY(AXIS_TREADY)
`ifdef OUTPUT_MEMS_TLAST_EN
        ,
        .AXIS_TLAST(AXIS_TLAST)
`endif
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    int    beat_cnt = 0;
    int    sent_cnt = 0;
    int    vcnt = 0;
    int    rdy_mode = 0;
    logic [31:0] model [DEPTH];
    beat_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    function automatic int exp_n(input int k);
        if (k < 1 || k > R || k > C) return 0;
        return (R - k + 1) * (C - k + 1);
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        y_wr_en   = 1'b1;
        y_wr_addr = AB'(a);
        y_wr_data = d;
        @(posedge clk); #1;
        y_wr_en = 1'b0;
        if (a < DEPTH) model[a] = d;
    endtask

    task automatic fill_random();
        for (int a = 0; a < DEPTH; a++) wr(a, $urandom());
    endtask

    task automatic run_frame(input int k, input bit timed, input int inj,
                             input bit cw, input logic [31:0] cwd);
        int n, cnt, s0, b0, v0;
        if (cw) model[0] = cwd;
        n = exp_n(k);
        for (int i = 0; i < n; i++) exp_q.push_back('{model[i], i == n - 1});
        s0 = sent_cnt;
        b0 = beat_cnt;
        v0 = vcnt;
        K = KB'(k);
        compute_finished = 1'b1;
        if (cw) begin
            y_wr_en   = 1'b1;
            y_wr_addr = '0;
            y_wr_data = cwd;
        end
        @(posedge clk); #1;
        compute_finished = 1'b0;
        y_wr_en = 1'b0;
        cnt = 0;
        while (!outputs_sent && cnt < 5000) begin
            if (n > 0 && cnt == 1) chk("lat_pre", 64'(AXIS_TVALID), 64'(0));
            if (n > 0 && cnt == 2) chk("lat_beat0", 64'(AXIS_TVALID), 64'(1));
            if (cnt == inj) begin
                y_wr_en = 1'b1;
                y_wr_addr = '0;
                y_wr_data = 32'hDEAD;
                compute_finished = 1'b1;
                K = KB'(1);
            end
            if (cnt == inj + 1) begin
                y_wr_en = 1'b0;
                compute_finished = 1'b0;
            end
            @(posedge clk); #1;
            cnt++;
        end
        y_wr_en = 1'b0;
        compute_finished = 1'b0;
        if (cnt >= 5000) fail("frame_timeout");
        if (timed) chk("frame_cycles", 64'(cnt), 64'((n == 0) ? 0 : n + 2));
        @(posedge clk); #1;
        chk("busy_after", 64'(output_busy), 64'(0));
        repeat (3) @(posedge clk);
        #1;
        chk("sent_once", 64'(sent_cnt - s0), 64'(1));
        chk("beats", 64'(beat_cnt - b0), 64'(n));
        chk("q_empty", 64'(exp_q.size()), 64'(0));
        if (n == 0) chk("no_valid", 64'(vcnt - v0), 64'(0));
    endtask

    // TREADY driver: always-on, 1,0,0,1 pattern, or random
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: AXIS_TREADY = 1'b1;
                1: begin
                    AXIS_TREADY = (ph % 4 == 0) || (ph % 4 == 3);
                    ph++;
                end
                default: AXIS_TREADY = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected beats on every handshake
    initial begin
        beat_t       e;
        logic        hold;
        logic [31:0] hd;
        hold = 1'b0;
        hd   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (AXIS_TVALID) begin
                    vcnt++;
                    if (hold) chk("stall_hold", 64'(AXIS_TDATA), 64'(hd));
                    if (AXIS_TREADY) begin
                        hold = 1'b0;
                        beat_cnt++;
                        if (exp_q.size() == 0) begin
                            fail("extra_beat");
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_data", 64'(AXIS_TDATA), 64'(e.d));
`ifdef OUTPUT_MEMS_TLAST_EN
                            chk("beat_last", 64'(AXIS_TLAST), 64'(e.l));
`endif
                        end
                    end else begin
                        hold = 1'b1;
                        hd   = AXIS_TDATA;
                    end
                end else begin
                    if (hold) fail("valid_drop");
                    hold = 1'b0;
                end
                if (outputs_sent) sent_cnt++;
            end
        end
    end

    // Stimulus
    initial begin
        int n, cnt, b0, s0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(output_busy), 64'(0));
        chk("rst_sent", 64'(outputs_sent), 64'(0));
        chk("rst_tvalid", 64'(AXIS_TVALID), 64'(0));
        chk("rst_tdata", 64'(AXIS_TDATA), 64'(0));
`ifdef OUTPUT_MEMS_TLAST_EN
        chk("rst_tlast", 64'(AXIS_TLAST), 64'(0));
`endif
        reset = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 143; a++) wr(a, 32'(a));
        rdy_mode = 0;
        run_frame(3, 1'b1, -1, 1'b0, '0);
        rdy_mode = 1;
        run_frame(3, 1'b0, -1, 1'b0, '0);

        rdy_mode = 2;
        fill_random();
        run_frame(7, 1'b0, -1, 1'b0, '0);
        fill_random();
        run_frame(1, 1'b0, -1, 1'b0, '0);

        wr(200, 32'hBAD0BAD0);
        run_frame(0, 1'b1, -1, 1'b0, '0);
        run_frame(14, 1'b1, -1, 1'b0, '0);

        run_frame(3, 1'b0, 20, 1'b0, '0);
        run_frame(3, 1'b0, -1, 1'b0, '0);
        run_frame(2, 1'b0, -1, 1'b1, $urandom());
        run_frame(1, 1'b0, -1, 1'b0, '0);

        // reset in the middle of a stream
        rdy_mode = 0;
        n = exp_n(3);
        for (int i = 0; i < n; i++) exp_q.push_back('{model[i], i == n - 1});
        b0 = beat_cnt;
        s0 = sent_cnt;
        K = KB'(3);
        compute_finished = 1'b1;
        @(posedge clk); #1;
        compute_finished = 1'b0;
        cnt = 0;
        while (beat_cnt - b0 < 50 && cnt < 1000) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 1000) fail("rst_wait_timeout");
        chk("pre_rst_valid", 64'(AXIS_TVALID), 64'(1));
        reset = 1'b0;
        #1;
        chk("midrst_tvalid", 64'(AXIS_TVALID), 64'(0));
        chk("midrst_busy", 64'(output_busy), 64'(0));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_idle", 64'(output_busy), 64'(0));
        chk("post_rst_nosent", 64'(sent_cnt - s0), 64'(0));
        run_frame(3, 1'b1, -1, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
